// File: rtl/n64adv2_vout_stage_if.sv
// Video/config bundle between the PPU scaler, the output stage and the ADV7513 side.
// The master drives the PPU-side inputs and config; the slave (output stage) drives pins and status.
interface n64adv2_vout_stage_if #(
  parameter int color_width = 8,
  parameter int num_ch      = 3,
  parameter int dly_w       = 3,
  parameter int meas_w      = 12
);
  logic                            VSYNC_i;
  logic                            HSYNC_i;
  logic                            DE_i;
  logic [num_ch*color_width-1:0]   VD_i;

  logic                            cfg_valid_i;
  logic [dly_w-1:0]                cfg_data_dly_i;
  logic [dly_w-1:0]                cfg_sync_dly_i;
  logic [1:0]                      cfg_pol_i;
  logic                            cfg_blank_i;
  logic                            cfg_ack_o;

  logic                            VSYNC_o;
  logic                            HSYNC_o;
  logic                            DE_o;
  logic [num_ch*color_width-1:0]   VD_o;

  logic [meas_w-1:0]               h_active_o;
  logic [meas_w-1:0]               v_active_o;
  logic                            stable_o;

  modport master (
    output VSYNC_i, HSYNC_i, DE_i, VD_i,
    output cfg_valid_i, cfg_data_dly_i, cfg_sync_dly_i, cfg_pol_i, cfg_blank_i,
    input  cfg_ack_o,
    input  VSYNC_o, HSYNC_o, DE_o, VD_o,
    input  h_active_o, v_active_o, stable_o
  );

  modport slave (
    input  VSYNC_i, HSYNC_i, DE_i, VD_i,
    input  cfg_valid_i, cfg_data_dly_i, cfg_sync_dly_i, cfg_pol_i, cfg_blank_i,
    output cfg_ack_o,
    output VSYNC_o, HSYNC_o, DE_o, VD_o,
    output h_active_o, v_active_o, stable_o
  );
endinterface

// File: rtl/n64adv2_vout_stage.sv
// HDMI-domain video output stage: programmable data/sync delay taps, sync polarity, forced blanking,
// frame-synchronous config update with ack, and active-area measurement with a stable flag.
module n64adv2_vout_stage #(
  parameter int color_width = 8,
  parameter int num_ch      = 3,
  parameter int max_dly     = 8,
  parameter int dly_w       = 3,
  parameter int meas_w      = 12
) (
  input logic                 VCLK_i,
  input logic                 VRST_i,
  n64adv2_vout_stage_if.slave vio
);

  localparam int PIX_W = num_ch * color_width;

  function automatic logic [dly_w-1:0] clamp_dly(input logic [dly_w-1:0] d);
    if (int'(d) > max_dly - 1) return dly_w'(max_dly - 1);
    return d;
  endfunction

  function automatic logic [meas_w-1:0] sat_inc(input logic [meas_w-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [PIX_W-1:0] blank_pix(input logic [PIX_W-1:0] pix,
                                                 input logic de, input logic blank);
    return (de && !blank) ? pix : '0;
  endfunction

  logic             vs_prev;
  logic             de_prev;
  logic             fs;
  logic             de_fall;

  logic             pend_flag;
  logic [dly_w-1:0] pend_ddly;
  logic [dly_w-1:0] pend_sdly;
  logic [1:0]       pend_pol;
  logic             pend_blank;

  logic [dly_w-1:0] act_ddly;
  logic [dly_w-1:0] act_sdly;
  logic [1:0]       act_pol;
  logic             act_blank;
  logic             ack_q;

  logic [PIX_W:0]   dat_in;
  logic [1:0]       syn_in;
  logic [PIX_W:0]   dat_q [1:max_dly-1];
  logic [1:0]       syn_q [1:max_dly-1];
  logic [PIX_W:0]   dat_tap;
  logic [1:0]       syn_tap;

  logic [PIX_W-1:0] vd_q;
  logic             de_q;
  logic             vs_q;
  logic             hs_q;

  logic [meas_w-1:0] pix_cnt;
  logic [meas_w-1:0] line_w;
  logic [meas_w-1:0] line_cnt;
  logic [meas_w-1:0] h_act;
  logic [meas_w-1:0] v_act;
  logic [meas_w-1:0] prev_h;
  logic [meas_w-1:0] prev_v;
  logic              stable_q;

  // Frame start and line end are taken from the raw inputs, before any delay or polarity.
  assign fs      = vio.VSYNC_i & ~vs_prev;
  assign de_fall = de_prev & ~vio.DE_i;
  assign dat_in  = {vio.DE_i, vio.VD_i};
  assign syn_in  = {vio.VSYNC_i, vio.HSYNC_i};

  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
    end else begin
      vs_prev <= vio.VSYNC_i;
      de_prev <= vio.DE_i;
    end
  end

  // Config capture and frame-synchronous apply; a strobe coinciding with fs queues for the next fs.
  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      pend_flag  <= 1'b0;
      pend_ddly  <= '0;
      pend_sdly  <= '0;
      pend_pol   <= '0;
      pend_blank <= 1'b0;
      act_ddly   <= '0;
      act_sdly   <= '0;
      act_pol    <= '0;
      act_blank  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= fs && pend_flag;
      if (fs && pend_flag) begin
        act_ddly  <= pend_ddly;
        act_sdly  <= pend_sdly;
        act_pol   <= pend_pol;
        act_blank <= pend_blank;
      end
      if (vio.cfg_valid_i) begin
        pend_ddly  <= clamp_dly(vio.cfg_data_dly_i);
        pend_sdly  <= clamp_dly(vio.cfg_sync_dly_i);
        pend_pol   <= vio.cfg_pol_i;
        pend_blank <= vio.cfg_blank_i;
        pend_flag  <= 1'b1;
      end else if (fs) begin
        pend_flag  <= 1'b0;
      end
    end
  end

  // Stage p0: free-running delay lines, entry k holds the sample from k cycles ago.
  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      for (int k = 1; k < max_dly; k++) begin
        dat_q[k] <= '0;
        syn_q[k] <= '0;
      end
    end else begin
      dat_q[1] <= dat_in;
      syn_q[1] <= syn_in;
      for (int k = 2; k < max_dly; k++) begin
        dat_q[k] <= dat_q[k-1];
        syn_q[k] <= syn_q[k-1];
      end
    end
  end

  always_comb begin
    dat_tap = dat_in;
    syn_tap = syn_in;
    for (int k = 1; k < max_dly; k++) begin
      if (act_ddly == dly_w'(k)) dat_tap = dat_q[k];
      if (act_sdly == dly_w'(k)) syn_tap = syn_q[k];
    end
  end

  // Stage p1: output register, the only stage in the path when both taps are 0.
  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      vd_q <= '0;
      de_q <= 1'b0;
      vs_q <= 1'b0;
      hs_q <= 1'b0;
    end else begin
      vd_q <= blank_pix(dat_tap[PIX_W-1:0], dat_tap[PIX_W], act_blank);
      de_q <= dat_tap[PIX_W];
      vs_q <= syn_tap[1] ^ act_pol[1];
      hs_q <= syn_tap[0] ^ act_pol[0];
    end
  end

  // Active-area measurement; results and the stable flag update once per frame start.
  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      pix_cnt  <= '0;
      line_w   <= '0;
      line_cnt <= '0;
      h_act    <= '0;
      v_act    <= '0;
      prev_h   <= '0;
      prev_v   <= '0;
      stable_q <= 1'b0;
    end else begin
      if (de_fall) begin
        line_w  <= pix_cnt;
        pix_cnt <= '0;
      end else if (vio.DE_i) begin
        pix_cnt <= sat_inc(pix_cnt);
      end
      if (fs) begin
        h_act    <= line_w;
        v_act    <= line_cnt;
        prev_h   <= line_w;
        prev_v   <= line_cnt;
        stable_q <= (line_w == prev_h) && (line_cnt == prev_v) && (line_cnt != '0);
        line_cnt <= '0;
      end else if (de_fall) begin
        line_cnt <= sat_inc(line_cnt);
      end
    end
  end

  assign vio.cfg_ack_o  = ack_q;
  assign vio.VD_o       = vd_q;
  assign vio.DE_o       = de_q;
  assign vio.VSYNC_o    = vs_q;
  assign vio.HSYNC_o    = hs_q;
  assign vio.h_active_o = h_act;
  assign vio.v_active_o = v_act;
  assign vio.stable_o   = stable_q;

endmodule
